instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the decode-stage immediate extender: packs an opcode, register fields and a 32-bit signed immediate into a RV32I instruction word.
- Scrambles the immediate bits per format (I/S/B/J/U/R) and expands the LI pseudo-op into LUI+ADDI.
- Used by the boot/self-test instruction injector feeding the fetch-stage instruction buffer.
- Valid/ready request input; one-entry registered valid/ready output.

Parameters:
- XLEN, 32, data/immediate width; only 32 is supported.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ReqValid  in  1  request present
- ReqReady  out  1  request accepted when ReqValid&&ReqReady at clk edge
- FmtSel  in  3  000 I, 001 S, 010 B, 011 J, 100 U, 101 R, 110 LI; 111 reserved, treated as R
- Opcode  in  7  opcode field; ignored for LI
- Rd, Rs1, Rs2  in  5 each  register fields
- Funct3  in  3  funct3 field
- Funct7  in  7  funct7 field (R only)
- Imm  in  32  signed immediate, byte offset for B/J, full value for U/LI
- InstrOut  out  32  encoded instruction
- InstrValid  out  1  InstrOut valid
- InstrReady  in  1  consumer accepts on InstrValid&&InstrReady
- ImmErr  out  1  one-cycle pulse: request dropped, immediate out of range

Behaviour:
- Reset (async, rst_n=0): InstrOut=0, InstrValid=0, ImmErr=0, FSM=IDLE, pending LI state cleared. Takes effect immediately, including mid-LI.
- Output slot is free when !InstrValid || InstrReady.
- ReqReady = (state==IDLE) && slot free.
- Latency: request accepted at edge N gives InstrValid=1 after edge N. Full throughput of 1 word/cycle for single-word formats.
- Field packing:
  - I: Imm[11:0],Rs1,Funct3,Rd,Opcode
  - S: Imm[11:5],Rs2,Rs1,Funct3,Imm[4:0],Opcode
  - B: Imm[12],Imm[10:5],Rs2,Rs1,Funct3,Imm[4:1],Imm[11],Opcode
  - J: Imm[20],Imm[10:1],Imm[11],Imm[19:12],Rd,Opcode
  - U: Imm[31:12],Rd,Opcode
  - R: Funct7,Rs2,Rs1,Funct3,Rd,Opcode; Imm ignored
- LI expansion:
  - lo = sign-extended Imm[11:0]; hi = (Imm + 0x800)[31:12], modulo 2^32 wrap.
  - If hi==0: emit only ADDI Rd,x0,lo (opcode 0010011, funct3 000).
  - Else: emit LUI Rd,hi (opcode 0110111), latch Rd and lo, go to LI_LO.
- FSM:
  - IDLE: accepting requests.
  - LI_LO: ReqReady=0. When slot free, load ADDI Rd,Rd,lo and return to IDLE.
- Output register holds InstrOut and InstrValid stable while InstrValid && !InstrReady.
- Rd==0 is encoded as given; no special casing.
- ImmErr: asserted for exactly one cycle after the accepting edge. No word is loaded for that request. InstrValid unaffected (a prior word keeps draining).

Optional Feature:
- Macro IMM_RANGE_CHECK_EN.
- Defined: accepted requests are range-checked:
  - I/S: -2048..2047
  - B: -4096..4094 and Imm[0]==0
  - J: -1048576..1048574 and Imm[0]==0
  - U: Imm[11:0]==0
  - R/LI: never fail
  - A failing request is dropped with an ImmErr pulse.
- Undefined: no checks; immediates are silently truncated/scrambled as above; ImmErr tied 0.

Test Plan:
- I ADDI: FmtSel=000, Opcode=0010011, Funct3=0, Rd=5, Rs1=6, Imm=0xFFFFFFFF, InstrReady=1 -> next cycle InstrOut=0xFFF30293, InstrValid=1.
- S SW: FmtSel=001, Opcode=0100011, Funct3=010, Rs1=2, Rs2=7, Imm=8 -> InstrOut=0x00712423.
- B BEQ: FmtSel=010, Opcode=1100011, Funct3=0, Rs1=1, Rs2=2, Imm=-4 -> InstrOut=0xFE208EE3. With IMM_RANGE_CHECK_EN, Imm=3 -> no InstrValid, ImmErr high exactly 1 cycle.
- LI: FmtSel=110, Rd=10, Imm=0x12345FFF, InstrReady=1 -> 0x12346537 then 0xFFF50513 on consecutive cycles; ReqReady=0 during the second cycle. Imm=5, Rd=10 -> single word 0x00500513.
- Backpressure: InstrReady=0 for 5 cycles after a word is loaded -> InstrOut/InstrValid stable, ReqReady=0; on InstrReady=1, next request loads the same cycle.
- Reset mid-LI: drop rst_n while in LI_LO with LUI pending -> InstrValid=0 immediately. After release, ReqReady=1 and the ADDI word is never emitted.

Source files
------------

// File: rtl/instr_encoder_if.sv
// instr_encoder_if: request and output handshake bundle
// for the RV32I instruction encoder.
interface instr_encoder_if;
  logic        ReqValid;
  logic        ReqReady;
  logic [2:0]  FmtSel;
  logic [6:0]  Opcode;
  logic [4:0]  Rd;
  logic [4:0]  Rs1;
  logic [4:0]  Rs2;
  logic [2:0]  Funct3;
  logic [6:0]  Funct7;
  logic [31:0] Imm;
  logic [31:0] InstrOut;
  logic        InstrValid;
  logic        InstrReady;
  logic        ImmErr;

  modport master (
    output ReqValid, FmtSel, Opcode,
    output Rd, Rs1, Rs2, Funct3, Funct7, Imm,
    output InstrReady,
    input  ReqReady, InstrOut, InstrValid, ImmErr
  );

  modport slave (
    input  ReqValid, FmtSel, Opcode,
    input  Rd, Rs1, Rs2, Funct3, Funct7, Imm,
    input  InstrReady,
    output ReqReady, InstrOut, InstrValid, ImmErr
  );
endinterface

// File: rtl/instr_encoder.sv
// instr_encoder: packs fields + immediate into RV32I words,
// expands LI into LUI+ADDI. Option: IMM_RANGE_CHECK_EN.
module instr_encoder #(
  parameter int XLEN = 32
) (
  input logic           clk,
  input logic           rst_n,
  instr_encoder_if.slave bus
);

  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  typedef enum logic {IDLE, LI_LO} state_t;

  state_t      state, state_n;
  logic [31:0] out_q, word_n, req_word;
  logic        vld_q, load, li_set, li_two;
  logic [4:0]  rd_q;
  logic [11:0] lo_q;
  logic        slot_free, accept, imm_bad;
  logic [XLEN-1:0] li_sum;
  logic [19:0] li_hi;
  logic        is_i, is_s, is_b, is_j;
  logic        is_u, is_r, is_li;

  assign slot_free    = !vld_q || bus.InstrReady;
  assign bus.ReqReady = (state == IDLE) && slot_free;
  assign accept       = bus.ReqValid && bus.ReqReady;
  assign bus.InstrOut   = out_q;
  assign bus.InstrValid = vld_q;

  assign li_sum = bus.Imm + 32'h800;
  assign li_hi  = li_sum[31:12];

  assign is_i  = bus.FmtSel == 3'b000;
  assign is_s  = bus.FmtSel == 3'b001;
  assign is_b  = bus.FmtSel == 3'b010;
  assign is_j  = bus.FmtSel == 3'b011;
  assign is_u  = bus.FmtSel == 3'b100;
  assign is_li = bus.FmtSel == 3'b110;
  assign is_r  = bus.FmtSel == 3'b101 ||
                 bus.FmtSel == 3'b111;

  // Scramble immediate and fields into one word per format
  always_comb begin
    req_word = '0;
    li_two   = 1'b0;
    unique case (1'b1)
      is_i: req_word = {bus.Imm[11:0], bus.Rs1,
                        bus.Funct3, bus.Rd, bus.Opcode};
      is_s: req_word = {bus.Imm[11:5], bus.Rs2,
                        bus.Rs1, bus.Funct3,
                        bus.Imm[4:0], bus.Opcode};
      is_b: req_word = {bus.Imm[12], bus.Imm[10:5],
                        bus.Rs2, bus.Rs1, bus.Funct3,
                        bus.Imm[4:1], bus.Imm[11],
                        bus.Opcode};
      is_j: req_word = {bus.Imm[20], bus.Imm[10:1],
                        bus.Imm[11], bus.Imm[19:12],
                        bus.Rd, bus.Opcode};
      is_u: req_word = {bus.Imm[31:12], bus.Rd,
                        bus.Opcode};
      is_li: begin
        if (li_hi == 20'd0) begin
          req_word = {bus.Imm[11:0], 5'd0, 3'b000,
                      bus.Rd, OP_IMM};
        end else begin
          req_word = {li_hi, bus.Rd, OP_LUI};
          li_two   = 1'b1;
        end
      end
      default: req_word = {bus.Funct7, bus.Rs2,
                           bus.Rs1, bus.Funct3,
                           bus.Rd, bus.Opcode};
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  logic signed [31:0] simm;
  logic               err_q;

  assign simm = bus.Imm;

  // Flag immediates the selected format cannot hold
  always_comb begin
    imm_bad = 1'b0;
    unique case (1'b1)
      is_i, is_s: imm_bad = simm < -2048 ||
                            simm > 2047;
      is_b: imm_bad = simm < -4096 || simm > 4094 ||
                      bus.Imm[0];
      is_j: imm_bad = simm < -1048576 ||
                      simm > 1048574 || bus.Imm[0];
      is_u: imm_bad = bus.Imm[11:0] != 12'd0;
      default: imm_bad = 1'b0;
    endcase
  end

  // One-cycle pulse for a dropped request
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= accept && imm_bad;
  end

  assign bus.ImmErr = err_q;
`else
  assign imm_bad    = 1'b0;
  assign bus.ImmErr = 1'b0;
`endif

  // Next state and output-slot load decision
  always_comb begin
    state_n = state;
    load    = 1'b0;
    li_set  = 1'b0;
    word_n  = req_word;
    unique case (state)
      IDLE: begin
        if (accept && !imm_bad) begin
          load = 1'b1;
          if (li_two) begin
            li_set  = 1'b1;
            state_n = LI_LO;
          end
        end
      end
      LI_LO: begin
        if (slot_free) begin
          load    = 1'b1;
          word_n  = {lo_q, rd_q, 3'b000, rd_q, OP_IMM};
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Output slot and pending LI low half
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= '0;
      vld_q <= 1'b0;
      rd_q  <= '0;
      lo_q  <= '0;
    end else begin
      if (load) begin
        out_q <= word_n;
        vld_q <= 1'b1;
      end else if (bus.InstrReady) begin
        vld_q <= 1'b0;
      end
      if (li_set) begin
        rd_q <= bus.Rd;
        lo_q <= bus.Imm[11:0];
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: scoreboard bench for instr_encoder.
// Expected words queued at drive time, compared on output.
module tb_instr_encoder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_cyc[$];

  always #5 clk = ~clk;

  instr_encoder_if bus();

  instr_encoder #(.XLEN(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always @(posedge clk) cyc++;

  always @(negedge clk)
    if (rst_n && bus.InstrValid && bus.InstrReady) begin
      got_q.push_back(bus.InstrOut);
      got_cyc.push_back(cyc);
    end

  function automatic logic [31:0] model(
    input logic [2:0] f, input logic [6:0] op,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] i);
    logic [31:0] w;
    logic [31:0] regs;
    regs = (32'(rs2) << 20) | (32'(rs1) << 15) |
           (32'(f3) << 12);
    w = {25'd0, op};
    case (f)
      3'd0: w |= (i << 20) | (32'(rs1) << 15) |
                 (32'(f3) << 12) | (32'(rd) << 7);
      3'd1: w |= (((i >> 5) & 32'h7F) << 25) | regs |
                 ((i & 32'h1F) << 7);
      3'd2: w |= (32'(i[12]) << 31) | regs |
                 (((i >> 5) & 32'h3F) << 25) |
                 (((i >> 1) & 32'hF) << 8) |
                 (32'(i[11]) << 7);
      3'd3: w |= (32'(i[20]) << 31) |
                 (((i >> 1) & 32'h3FF) << 21) |
                 (32'(i[11]) << 20) |
                 (i & 32'h000FF000) | (32'(rd) << 7);
      3'd4: w |= (i & 32'hFFFFF000) | (32'(rd) << 7);
      default: w |= (32'(f7) << 25) | regs |
                    (32'(rd) << 7);
    endcase
    return w;
  endfunction

  task automatic send(
    input logic [2:0] fmt, input logic [6:0] op,
    input logic [4:0] rd, input logic [4:0] rs1,
    input logic [4:0] rs2, input logic [2:0] f3,
    input logic [6:0] f7, input logic [31:0] imm);
    bit acc;
    int n;
    bus.FmtSel = fmt;
    bus.Opcode = op;
    bus.Rd = rd;
    bus.Rs1 = rs1;
    bus.Rs2 = rs2;
    bus.Funct3 = f3;
    bus.Funct7 = f7;
    bus.Imm = imm;
    bus.ReqValid = 1'b1;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 20) begin
      @(negedge clk);
      acc = bus.ReqReady;
      @(posedge clk);
      #1;
      n++;
    end
    bus.ReqValid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout fmt=%0d got no ReqReady in 20 cycles",
               fmt);
    end
  endtask

  task automatic wait_drain(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic flush();
    exp_q.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  task automatic test_reset();
    bus.ReqValid = 1'b0;
    bus.InstrReady = 1'b0;
    bus.FmtSel = '0;
    bus.Opcode = '0;
    bus.Rd = '0;
    bus.Rs1 = '0;
    bus.Rs2 = '0;
    bus.Funct3 = '0;
    bus.Funct7 = '0;
    bus.Imm = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL rst_valid got=%b exp=0", bus.InstrValid);
    end
    checks++;
    if (bus.InstrOut !== 32'h0) begin
      failures++;
      $display("FAIL rst_out got=%h exp=0", bus.InstrOut);
    end
    checks++;
    if (bus.ImmErr !== 1'b0) begin
      failures++;
      $display("FAIL rst_err got=%b exp=0", bus.ImmErr);
    end
    checks++;
    if (bus.ReqReady !== 1'b1) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=1", bus.ReqReady);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_formats();
    flush();
    bus.InstrReady = 1'b1;
    send(3'd0, 7'h13, 5, 6, 0, 3'd0, 0, 32'hFFFFFFFF);
    exp_q.push_back(32'hFFF30293);
    send(3'd0, 7'h13, 5, 6, 0, 3'd0, 0, 32'd2047);
    exp_q.push_back(32'h7FF30293);
    send(3'd0, 7'h13, 5, 6, 0, 3'd0, 0, -32'sd2048);
    exp_q.push_back(32'h80030293);
    send(3'd1, 7'h23, 0, 2, 7, 3'd2, 0, 32'd8);
    exp_q.push_back(32'h00712423);
    send(3'd2, 7'h63, 0, 1, 2, 3'd0, 0, -32'sd4);
    exp_q.push_back(32'hFE208EE3);
    send(3'd2, 7'h63, 0, 1, 2, 3'd0, 0, 32'd4094);
    exp_q.push_back(32'h7E208FE3);
    send(3'd3, 7'h6F, 1, 0, 0, 3'd0, 0, -32'sd2);
    exp_q.push_back(32'hFFFFF0EF);
    send(3'd3, 7'h6F, 1, 0, 0, 3'd0, 0, 32'd2048);
    exp_q.push_back(32'h001000EF);
    send(3'd4, 7'h37, 1, 0, 0, 3'd0, 0, 32'hABCDE000);
    exp_q.push_back(32'hABCDE0B7);
    send(3'd5, 7'h33, 1, 2, 3, 3'd0, 7'h20, 32'hDEADBEEF);
    exp_q.push_back(32'h403100B3);
    send(3'd7, 7'h33, 1, 2, 3, 3'd0, 7'h20, 32'h12345678);
    exp_q.push_back(32'h403100B3);
    wait_drain(exp_q.size());
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL fmt_count got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && got_q.size() > 0; k++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL fmt_word%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

  task automatic test_li();
    flush();
    bus.InstrReady = 1'b1;
    send(3'd6, 7'h7F, 10, 0, 0, 3'd0, 0, 32'h12345FFF);
    @(negedge clk);
    checks++;
    if (bus.ReqReady !== 1'b0) begin
      failures++;
      $display("FAIL li_busy ReqReady got=%b exp=0", bus.ReqReady);
    end
    exp_q.push_back(32'h12346537);
    exp_q.push_back(32'hFFF50513);
    wait_drain(2);
    checks++;
    if (got_cyc.size() != 2 || got_cyc[1] != got_cyc[0] + 1) begin
      failures++;
      $display("FAIL li_consec got=%0d words exp=2 on consecutive cycles",
               got_cyc.size());
    end
    send(3'd6, 7'h00, 10, 0, 0, 3'd0, 0, 32'd5);
    exp_q.push_back(32'h00500513);
    send(3'd6, 7'h00, 10, 0, 0, 3'd0, 0, 32'hFFFFF800);
    exp_q.push_back(32'h80000513);
    send(3'd6, 7'h00, 10, 0, 0, 3'd0, 0, 32'h00000800);
    exp_q.push_back(32'h00001537);
    exp_q.push_back(32'h80050513);
    send(3'd6, 7'h00, 10, 0, 0, 3'd0, 0, 32'h7FFFF800);
    exp_q.push_back(32'h80000537);
    exp_q.push_back(32'h80050513);
    wait_drain(exp_q.size());
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL li_count got=%0d exp=%0d",
               got_q.size(), exp_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && got_q.size() > 0; k++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL li_word%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

  task automatic test_backpressure();
    flush();
    bus.InstrReady = 1'b0;
    send(3'd0, 7'h13, 5, 6, 0, 3'd0, 0, 32'd1);
    exp_q.push_back(32'h00130293);
    bus.FmtSel = 3'd1;
    bus.Opcode = 7'h23;
    bus.Rs1 = 2;
    bus.Rs2 = 7;
    bus.Funct3 = 3'd2;
    bus.Imm = 32'd8;
    bus.ReqValid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      checks++;
      if (bus.InstrValid !== 1'b1 || bus.InstrOut !== 32'h00130293 ||
          bus.ReqReady !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold%0d got v=%b out=%h rr=%b exp v=1 out=00130293 rr=0",
                 k, bus.InstrValid, bus.InstrOut, bus.ReqReady);
      end
      @(posedge clk);
      #1;
    end
    bus.InstrReady = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.ReqReady !== 1'b1) begin
      failures++;
      $display("FAIL bp_release ReqReady got=%b exp=1", bus.ReqReady);
    end
    @(posedge clk);
    #1;
    bus.ReqValid = 1'b0;
    exp_q.push_back(32'h00712423);
    checks++;
    if (bus.InstrOut !== 32'h00712423 || bus.InstrValid !== 1'b1) begin
      failures++;
      $display("FAIL bp_next got=%h v=%b exp=00712423 v=1",
               bus.InstrOut, bus.InstrValid);
    end
    wait_drain(2);
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL bp_count got=%0d exp=2", got_q.size());
    end
    for (int k = 0; exp_q.size() > 0 && got_q.size() > 0; k++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL bp_word%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    flush();
    bus.InstrReady = 1'b1;
    for (int k = 0; k < 10; k++) begin
      logic [2:0] f;
      logic [31:0] imm;
      logic [6:0] op, f7;
      logic [4:0] rd, r1, r2;
      logic [2:0] f3;
      int v;
      f = 3'($urandom_range(0, 5));
      op = 7'($urandom);
      f7 = 7'($urandom);
      rd = 5'($urandom);
      r1 = 5'($urandom);
      r2 = 5'($urandom);
      f3 = 3'($urandom);
      imm = $urandom;
      case (f)
        3'd0, 3'd1: begin
          v = int'($urandom_range(0, 4095)) - 2048;
          imm = v;
        end
        3'd2: begin
          v = 2 * (int'($urandom_range(0, 4095)) - 2048);
          imm = v;
        end
        3'd3: begin
          v = 2 * (int'($urandom_range(0, 1048575)) - 524288);
          imm = v;
        end
        3'd4: imm = imm & 32'hFFFFF000;
        default: ;
      endcase
      exp_q.push_back(model(f, op, rd, r1, r2, f3, f7, imm));
      send(f, op, rd, r1, r2, f3, f7, imm);
    end
    wait_drain(exp_q.size());
    checks++;
    if (got_cyc.size() != 10 || got_cyc[9] != got_cyc[0] + 9) begin
      failures++;
      $display("FAIL b2b_rate got=%0d words exp=10 on consecutive cycles",
               got_cyc.size());
    end
    for (int k = 0; exp_q.size() > 0 && got_q.size() > 0; k++) begin
      logic [31:0] e, g;
      e = exp_q.pop_front();
      g = got_q.pop_front();
      checks++;
      if (g !== e) begin
        failures++;
        $display("FAIL b2b_word%0d got=%h exp=%h", k, g, e);
      end
    end
  endtask

  task automatic test_imm_err();
    flush();
    bus.InstrReady = 1'b1;
`ifdef IMM_RANGE_CHECK_EN
    send(3'd2, 7'h63, 0, 1, 2, 3'd0, 0, 32'd3);
    checks++;
    if (bus.ImmErr !== 1'b1 || bus.InstrValid !== 1'b0) begin
      failures++;
      $display("FAIL err_pulse got err=%b v=%b exp err=1 v=0",
               bus.ImmErr, bus.InstrValid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.ImmErr !== 1'b0) begin
      failures++;
      $display("FAIL err_width got=%b exp=0", bus.ImmErr);
    end
    send(3'd0, 7'h13, 5, 6, 0, 3'd0, 0, 32'd2048);
    checks++;
    if (bus.ImmErr !== 1'b1) begin
      failures++;
      $display("FAIL err_irange got=%b exp=1", bus.ImmErr);
    end
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (got_q.size() != 0) begin
      failures++;
      $display("FAIL err_noword got=%0d words exp=0", got_q.size());
    end
`else
    send(3'd0, 7'h13, 5, 6, 0, 3'd0, 0, 32'h00001234);
    checks++;
    if (bus.ImmErr !== 1'b0 || bus.InstrOut !== 32'h23430293) begin
      failures++;
      $display("FAIL trunc got err=%b out=%h exp err=0 out=23430293",
               bus.ImmErr, bus.InstrOut);
    end
    send(3'd2, 7'h63, 0, 1, 2, 3'd0, 0, 32'd3);
    checks++;
    if (bus.ImmErr !== 1'b0 || bus.InstrOut !== 32'h00208163) begin
      failures++;
      $display("FAIL trunc_b got err=%b out=%h exp err=0 out=00208163",
               bus.ImmErr, bus.InstrOut);
    end
`endif
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_li();
    bus.InstrReady = 1'b1;
    send(3'd6, 7'h00, 10, 0, 0, 3'd0, 0, 32'h12345FFF);
    flush();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.InstrValid !== 1'b0 || bus.InstrOut !== 32'h0) begin
      failures++;
      $display("FAIL mid_rst got v=%b out=%h exp v=0 out=0",
               bus.InstrValid, bus.InstrOut);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.ReqReady !== 1'b1 || got_q.size() != 0) begin
      failures++;
      $display("FAIL mid_rst_after got rr=%b words=%0d exp rr=1 words=0",
               bus.ReqReady, got_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_formats();
    test_li();
    test_backpressure();
    test_back_to_back();
    test_imm_err();
    test_reset_mid_li();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
